// File: rtl/systolic_pkg.sv
// -----------------------------------------------------------------------------
// systolic_pkg
//   Shared types for the systolic-array output deskew block.
//   - lane_word_t : one lane word at the default lane width
//   - state_t     : row-tracking FSM states (IDLE, ACTIVE)
//   - row_w()     : width of the row index, $clog2(rows) but never below 1
// -----------------------------------------------------------------------------
package systolic_pkg;

   localparam int LANE_B = 8;

   typedef logic [LANE_B-1:0] lane_word_t;

   typedef enum logic {
      IDLE   = 1'b0,
      ACTIVE = 1'b1
   } state_t;

   // A frame of one row still needs a 1-bit row index port.
   function automatic int row_w(input int rows);
      return (rows > 1) ? $clog2(rows) : 1;
   endfunction

endpackage

// File: rtl/systolic_deskew_lane.sv
// -----------------------------------------------------------------------------
// deskew_lane
//   D-stage shift register carrying one lane's {valid, data} word. D = 0
//   degenerates to a plain wire.
// Ports
//   clk      in  1   clock, posedge
//   rst_n    in  1   asynchronous active-low reset, clears every stage
//   clear    in  1   synchronous flush of every stage
//   in_word  in  W   {valid, data} entering the lane
//   out_word out W   {valid, data} after D cycles
// -----------------------------------------------------------------------------
module deskew_lane #(
   parameter int W = 9,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         clear,
   input  logic [W-1:0] in_word,
   output logic [W-1:0] out_word
);

   if (D == 0) begin : g_wire
      // Last lane: no delay, the common output register in the top is enough.
      logic unused_ctrl;
      assign unused_ctrl = &{1'b0, clk, rst_n, clear};
      assign out_word    = in_word;
   end else begin : g_shift
      logic [W-1:0] stage [D];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            for (int k = 0; k < D; k++) stage[k] <= '0;
         end else if (clear) begin
            for (int k = 0; k < D; k++) stage[k] <= '0;
         end else begin
            stage[0] <= in_word;
            for (int k = 1; k < D; k++) stage[k] <= stage[k-1];
         end
      end

      assign out_word = stage[D-1];
   end

endmodule

// File: rtl/systolic_deskew.sv
// -----------------------------------------------------------------------------
// systolic_deskew
//   Re-aligns the staggered lane outputs of the systolic array (lane i arrives
//   i cycles after lane 0) into one row vector with a single valid strobe,
//   tracks the row index inside a frame of ROWS rows and optionally flags
//   broken skew between lanes.
//
//   Optional feature macro: DESKEW_ERR_CHK_EN
//     defined   : skew_err is set (sticky) when the aligned lane valids differ
//     undefined : skew_err tied 0, valids of lanes 1..L-1 are ignored
//
// Handshake: no backpressure. out_valid is a one-cycle strobe per aligned row;
//   out_data/out_row/frame_done are meaningful only while out_valid is high
//   (out_data updates every cycle, out_row holds between rows).
//
// Ports
//   clk        in  1        clock, posedge
//   rst_n      in  1        asynchronous active-low reset
//   clear      in  1        synchronous flush of lanes, row count and skew_err
//   in_data    in  L*B      skewed lane words, lane i at [i*B +: B]
//   in_valid   in  L        skewed lane valids, bit i for lane i
//   out_data   out L*B      aligned row, lane i at [i*B +: B]
//   out_valid  out 1        aligned row strobe
//   out_row    out ROW_W    index of the row on out_data
//   frame_done out 1        high with out_valid of the last row of a frame
//   skew_err   out 1        sticky lane misalignment flag
//   row_state  out state_t  current row FSM state (observability)
// -----------------------------------------------------------------------------
module systolic_deskew
   import systolic_pkg::*;
#(
   parameter int B    = 8,
   parameter int L    = 4,
   parameter int ROWS = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     clear,
   input  logic [L*B-1:0]           in_data,
   input  logic [L-1:0]             in_valid,
   output logic [L*B-1:0]           out_data,
   output logic                     out_valid,
   output logic [row_w(ROWS)-1:0]   out_row,
   output logic                     frame_done,
   output logic                     skew_err,
   output state_t                   row_state
);

   localparam int ROW_W = row_w(ROWS);

   logic [B:0]     lane_out [L];
   logic [L-1:0]   aligned_valid;
   logic [L*B-1:0] aligned_data;

   // Lane i waits L-1-i cycles so every lane lines up with the last one.
   for (genvar i = 0; i < L; i++) begin : g_lane
      logic lane_valid_in;
`ifdef DESKEW_ERR_CHK_EN
      assign lane_valid_in = in_valid[i];
`else
      assign lane_valid_in = (i == 0) ? in_valid[0] : 1'b0;
`endif
      deskew_lane #(
         .W (B + 1),
         .D (L - 1 - i)
      ) u_lane (
         .clk      (clk),
         .rst_n    (rst_n),
         .clear    (clear),
         .in_word  ({lane_valid_in, in_data[i*B +: B]}),
         .out_word (lane_out[i])
      );
      assign aligned_valid[i]       = lane_out[i][B];
      assign aligned_data[i*B +: B] = lane_out[i][B-1:0];
   end

   // Row FSM. Rows are counted on lane 0 only; IDLE always carries row 0.
   state_t           state, state_nxt;
   logic [ROW_W-1:0] row_cnt, row_nxt;
   logic             row_v;
   logic             row_last;

   assign row_v     = aligned_valid[0];
   assign row_last  = (row_cnt == ROW_W'(ROWS - 1));
   assign row_state = state;

   always_comb begin
      state_nxt = state;
      row_nxt   = row_cnt;
      if (row_v) begin
         if (row_last) begin
            // Covers ROWS == 1 as well: the FSM never leaves IDLE.
            state_nxt = IDLE;
            row_nxt   = '0;
         end else begin
            state_nxt = ACTIVE;
            row_nxt   = row_cnt + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         row_cnt    <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_row    <= '0;
         frame_done <= 1'b0;
      end else if (clear) begin
         state      <= IDLE;
         row_cnt    <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_row    <= '0;
         frame_done <= 1'b0;
      end else begin
         state      <= state_nxt;
         row_cnt    <= row_nxt;
         out_data   <= aligned_data;
         out_valid  <= row_v;
         frame_done <= row_v && row_last;
         if (row_v) out_row <= row_cnt;
      end
   end

`ifdef DESKEW_ERR_CHK_EN
   // Any disagreement among aligned lane valids means the upstream skew broke.
   logic skew_bad;
   assign skew_bad = (aligned_valid != '0) && (aligned_valid != '1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)     skew_err <= 1'b0;
      else if (clear) skew_err <= 1'b0;
      else            skew_err <= skew_err | skew_bad;
   end
`else
   logic unused_valid;
   assign unused_valid = ^{in_valid, aligned_valid};
   assign skew_err     = 1'b0;
`endif

endmodule

// File: tb/tb_systolic_deskew.sv
module tb_systolic_deskew;
   import systolic_pkg::*;

   localparam int B    = 8;
   localparam int L    = 4;
   localparam int ROWS = 4;
   localparam int RW   = 2;

   // Scoreboard entry: {expected sample cycle, skew_err, frame_done, row, data}
   localparam int R_LSB  = L*B;
   localparam int FD_BIT = R_LSB + RW;
   localparam int SK_BIT = FD_BIT + 1;
   localparam int C_LSB  = SK_BIT + 1;
   localparam int EW     = C_LSB + 16;

   localparam int LATE_LANE = 2;
   localparam int KILL_LANE = L - 1;

   logic           clk;
   logic           rst_n;
   logic           clear;
   logic [L*B-1:0] in_data;
   logic [L-1:0]   in_valid;
   logic [L*B-1:0] out_data;
   logic           out_valid;
   logic [RW-1:0]  out_row;
   logic           frame_done;
   logic           skew_err;
   state_t         row_state;

   systolic_deskew #(.B(B), .L(L), .ROWS(ROWS)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .clear      (clear),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_row    (out_row),
      .frame_done (frame_done),
      .skew_err   (skew_err),
      .row_state  (row_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

   // ---------------- scoreboard state ----------------
   logic [EW-1:0]  exp_q[$];
   logic [L*B:0]   hist [L+1];   // input skewer: row requested k cycles ago
   logic [RW-1:0]  exp_row;
   logic           exp_sticky;
   logic           late_en;
   logic           kill_en;
   int             cyc;
   int             n_checks;
   int             n_fail;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"},      64'(out_valid),  64'd0);
      check({tag, "_data"},       64'(out_data),   64'd0);
      check({tag, "_row"},        64'(out_row),    64'd0);
      check({tag, "_frame_done"}, 64'(frame_done), 64'd0);
      check({tag, "_skew_err"},   64'(skew_err),   64'd0);
      check({tag, "_state"},      64'(row_state),  64'(IDLE));
   endtask

   task automatic monitor();
      logic [EW-1:0] e;
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", 64'd1, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("data",       64'(out_data),   64'(e[L*B-1:0]));
            check("row",        64'(out_row),    64'(e[R_LSB +: RW]));
            check("frame_done", 64'(frame_done), 64'(e[FD_BIT]));
            check("skew_err",   64'(skew_err),   64'(e[SK_BIT]));
            check("latency",    64'(16'(cyc)),   64'(e[C_LSB +: 16]));
         end
      end else begin
         check("idle_frame_done", 64'(frame_done), 64'd0);
         if (exp_q.size() > 0 && exp_q[0][C_LSB +: 16] <= 16'(cyc))
            check("missing_row", 64'(16'(cyc)), 64'(exp_q[0][C_LSB +: 16]));
      end
   endtask

   task automatic drive();
      for (int i = 0; i < L; i++) begin
         logic v;
         in_data[i*B +: B] = hist[i][i*B +: B];
         v = hist[i][L*B];
         if (late_en && i == LATE_LANE) v = hist[i+1][L*B];
         if (kill_en && i == KILL_LANE) v = 1'b0;
         in_valid[i] = v;
      end
   endtask

   task automatic flush_model();
      for (int k = 0; k <= L; k++) hist[k] = '0;
      exp_q.delete();
      exp_row    = '0;
      exp_sticky = 1'b0;
   endtask

   // One clock: sample outputs, advance the input skewer, optionally inject a row.
   task automatic step(input logic req, input logic [L*B-1:0] d, input logic bad);
      logic [EW-1:0] e;
      @(negedge clk);
      cyc++;
      monitor();
      clear = 1'b0;
      for (int k = L; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = {req, d};
      if (req) begin
`ifdef DESKEW_ERR_CHK_EN
         if (bad) exp_sticky = 1'b1;
`endif
         e = '0;
         e[L*B-1:0]     = d;
         e[R_LSB +: RW] = exp_row;
         e[FD_BIT]      = (exp_row == RW'(ROWS - 1));
         e[SK_BIT]      = exp_sticky;
         e[C_LSB +: 16] = 16'(cyc + L);
         exp_q.push_back(e);
         exp_row = (exp_row == RW'(ROWS - 1)) ? '0 : exp_row + 1'b1;
      end
      drive();
   endtask

   task automatic run(input int n);
      repeat (n) step(1'b0, '0, 1'b0);
   endtask

   task automatic drain();
      for (int k = 0; k < 4*L && exp_q.size() > 0; k++) step(1'b0, '0, 1'b0);
      check("drain_empty", 64'(exp_q.size()), 64'd0);
   endtask

   task automatic do_clear();
      @(negedge clk);
      cyc++;
      monitor();
      flush_model();
      clear = 1'b1;
      drive();
      step(1'b0, '0, 1'b0);
      check_zero("after_clear");
   endtask

   task automatic rand_rows(input int n);
      for (int r = 0; r < n; r++) step(1'b1, {$urandom, $urandom} , 1'b0);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst_n      = 1'b0;
      clear      = 1'b0;
      in_data    = '0;
      in_valid   = '0;
      late_en    = 1'b0;
      kill_en    = 1'b0;
      cyc        = 0;
      n_checks   = 0;
      n_fail     = 0;
      flush_model();
      repeat (2) @(negedge clk);
      check_zero("reset");
      rst_n = 1'b1;

      // Single aligned row, known pattern.
      step(1'b1, 32'h13121110, 1'b0);
      drain();
      run(2);
      check("single_row_gone", 64'(out_valid), 64'd0);

      // Two frames back-to-back.
      do_clear();
      rand_rows(2*ROWS);
      drain();

`ifdef DESKEW_ERR_CHK_EN
      // Lane 2 valid one cycle late on an isolated row, then good rows.
      do_clear();
      late_en = 1'b1;
      step(1'b1, {$urandom}, 1'b1);
      run(L + 1);
      late_en = 1'b0;
      rand_rows(3);
      drain();
      check("skew_sticky", 64'(skew_err), 64'd1);
`endif

      // Clear while rows are still inside the lanes.
      do_clear();
      rand_rows(ROWS);
      run(L - 3);
      do_clear();
      run(L + 2);
      step(1'b1, {$urandom}, 1'b0);
      drain();

`ifndef DESKEW_ERR_CHK_EN
      // Last lane never raises valid: rows still come out, no error.
      kill_en = 1'b1;
      rand_rows(3);
      drain();
      kill_en = 1'b0;
      check("no_skew_err", 64'(skew_err), 64'd0);
`endif

      // Asynchronous reset between edges while a row is on the output.
      do_clear();
      rand_rows(2);
      run(L);
      check("pre_reset_valid", 64'(out_valid), 64'd1);
      #1 rst_n = 1'b0;
      #1 check_zero("async_reset");
      flush_model();
      drive();
      run(2);
      rst_n = 1'b1;
      step(1'b1, {$urandom}, 1'b0);
      drain();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
